// File: rtl/cnt_share_ctrl.sv
// rtl/cnt_share_ctrl.sv - round-robin owner of one shared interval counter
// Grants the counter to one of two requesters for len+1 cycles, then pulses done.
module cnt_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_q,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             rr;
  logic [WIDTH-1:0] len_q;
  logic             pick;
  logic             owner_req;

  // rr names the requester favoured on a tie; it always points away from the last one served.
  assign pick      = (req0 && req1) ? rr : req1;
  assign owner_req = owner ? req1 : req0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    cnt_en    = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (req0 || req1) state_nxt = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        gnt0   = !owner;
        gnt1   = owner;
        // A dropped request wins over a completion landing on the same edge.
        if (!owner_req)          state_nxt = IDLE;
        else if (cnt_q == len_q) state_nxt = DONE;
      end
      DONE: begin
        done0     = !owner;
        done1     = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= 1'b0;
      rr    <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= pick;
            len_q <= pick ? len1 : len0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          if (!owner_req) begin
            cnt_q <= '0;
            rr    <= ~owner;
          end else if (cnt_q == len_q) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          rr <= ~owner;
        end
        default: ;
      endcase
    end
  end

endmodule
